// File: rtl/bcd_convert_arbiter.sv
// bcd_convert_arbiter: round-robin front end for two requesters sharing one double-dabble binary-to-BCD converter
module bcd_convert_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [7:0]  req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_data,
  output logic        req1_ready,
  output logic        rsp_valid,
  output logic [11:0] rsp_bcd,
  output logic        rsp_id,
  input  logic        rsp_ready,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state;
  logic [19:0] sr, adj;
  logic [3:0] cnt;
  logic last, id_l, g0, g1;
  always_comb begin
    g0 = req0_valid & (~req1_valid | last);
    g1 = req1_valid & (~req0_valid | ~last);
    req0_ready = ~rst & (state == IDLE) & g0;
    req1_ready = ~rst & (state == IDLE) & g1;
    adj[7:0] = sr[7:0];
    adj[11:8] = sr[11:8] >= 4'd5 ? sr[11:8] + 4'd3 : sr[11:8];
    adj[15:12] = sr[15:12] >= 4'd5 ? sr[15:12] + 4'd3 : sr[15:12];
    adj[19:16] = sr[19:16] >= 4'd5 ? sr[19:16] + 4'd3 : sr[19:16];
  end
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sr <= '0;
      cnt <= '0;
      last <= 1'b1;
      id_l <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_bcd <= '0;
      rsp_id <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req0_ready | req1_ready) begin
          sr <= {12'b0, req1_ready ? req1_data : req0_data};
          cnt <= '0;
          id_l <= req1_ready;
          last <= req1_ready;
          state <= SHIFT;
        end
        SHIFT: begin
          sr <= {adj[18:0], 1'b0};
          cnt <= cnt + 4'd1;
          if (cnt == 4'd7) begin
            state <= DONE;
            rsp_valid <= 1'b1;
            rsp_bcd <= adj[18:7];
            rsp_id <= id_l;
          end
        end
        DONE: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// tb_bcd_convert_arbiter: scoreboard bench with a decimal-arithmetic reference model
module tb_bcd_convert_arbiter;
  logic clk = 0, rst = 1;
  logic req0_valid = 0, req1_valid = 0, rsp_ready = 0;
  logic [7:0] req0_data = 0, req1_data = 0;
  logic req0_ready, req1_ready, rsp_valid, rsp_id, busy;
  logic [11:0] rsp_bcd;
  bit bp = 0, rdy_fix = 1, fin = 0, fin_done = 0;
  int checks = 0, errors = 0;

  bcd_convert_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_bcd(rsp_bcd), .rsp_id(rsp_id),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) #2 rsp_ready = bp ? 1'($urandom_range(0, 1)) : rdy_fix;

  function automatic logic [11:0] dec(input int v);
    return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + v % 10);
  endfunction

  task automatic ck(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard/monitor: all comparisons live here, sampled on the falling edge
  logic [12:0] q[$];
  logic [12:0] e;
  bit last_m = 1, was_rst = 0, pend = 0, p_valid = 0, p_take = 0, p_id = 0;
  logic [11:0] p_bcd = 0;
  int lat = 0;
  always @(negedge clk) begin
    if (rst) begin
      ck("rst_ready", int'({req1_ready, req0_ready}), 0);
      q.delete();
      pend = 0;
      last_m = 1;
    end else begin
      if (was_rst) begin
        ck("rst_valid", int'(rsp_valid), 0);
        ck("rst_busy", int'(busy), 0);
        ck("rst_bcd", int'(rsp_bcd), 0);
        ck("rst_id", int'(rsp_id), 0);
      end
      if (busy) ck("ready_busy", int'({req1_ready, req0_ready}), 0);
      else ck("grant", int'({req1_ready, req0_ready}),
              (req0_valid && req1_valid) ? (last_m ? 1 : 2) : int'({req1_valid, req0_valid}));
      if (pend) lat++;
      if (rsp_valid && !p_valid) begin
        ck("latency", lat, 9);
        pend = 0;
      end
      if (!was_rst && p_valid && !p_take) begin
        ck("hold_valid", int'(rsp_valid), 1);
        ck("hold_bcd", int'(rsp_bcd), int'(p_bcd));
        ck("hold_id", int'(rsp_id), int'(p_id));
      end
      if (!was_rst && !rsp_valid) begin
        ck("idle_bcd", int'(rsp_bcd), int'(p_bcd));
        ck("idle_id", int'(rsp_id), int'(p_id));
      end
      if (p_take) ck("idle_after_rsp", int'(busy), 0);
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) ck("unexpected_rsp", 1, 0);
        else begin
          e = q.pop_front();
          ck("rsp_bcd", int'(rsp_bcd), int'(e[11:0]));
          ck("rsp_id", int'(rsp_id), int'(e[12]));
        end
      end
      if (req0_valid && req0_ready) begin
        q.push_back({1'b0, dec(int'(req0_data))});
        last_m = 0;
        pend = 1;
        lat = 0;
      end
      if (req1_valid && req1_ready) begin
        q.push_back({1'b1, dec(int'(req1_data))});
        last_m = 1;
        pend = 1;
        lat = 0;
      end
      if (fin && !fin_done) begin
        ck("queue_empty", q.size(), 0);
        fin_done = 1;
      end
    end
    p_valid = rsp_valid;
    p_take = rsp_valid && rsp_ready && !rst;
    p_bcd = rsp_bcd;
    p_id = rsp_id;
    was_rst = rst;
  end

  // Present the enabled requests and withdraw each one after it is accepted
  task automatic drive(input bit e0, input bit e1, input logic [7:0] a, input logic [7:0] b);
    bit t0, t1;
    int n = 0;
    req0_valid = e0; req0_data = a;
    req1_valid = e1; req1_data = b;
    while ((req0_valid || req1_valid) && n < 400) begin
      @(negedge clk);
      t0 = req0_valid && req0_ready;
      t1 = req1_valid && req1_ready;
      @(posedge clk);
      #1;
      if (t0) req0_valid = 0;
      if (t1) req1_valid = 0;
      n++;
    end
    if (n >= 400) begin
      $display("FAIL drive_timeout: got no acceptance expected acceptance");
      $fatal(1);
    end
  endtask

  task automatic wait_quiet();
    int n = 0;
    while ((busy || rsp_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      $display("FAIL idle_timeout: got busy expected idle");
      $fatal(1);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n, acc;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    drive(1, 0, 8'd255, 8'd0);
    wait_quiet();
    req0_valid = 1; req0_data = 8'd0;
    req1_valid = 1; req1_data = 8'd99;
    acc = 0; n = 0;
    while (acc < 3 && n < 400) begin
      @(negedge clk);
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) acc++;
      n++;
    end
    if (n >= 400) begin
      $display("FAIL contention_timeout: got %0d acceptances expected 3", acc);
      $fatal(1);
    end
    @(posedge clk);
    #1 req0_valid = 0; req1_valid = 0;
    wait_quiet();
    rdy_fix = 0;
    drive(0, 1, 8'd0, 8'd47);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(posedge clk);
    #1 rdy_fix = 1;
    wait_quiet();
    drive(1, 0, 8'd200, 8'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    drive(0, 1, 8'd0, 8'd128);
    wait_quiet();
    bp = 1;
    for (int v = 0; v < 256; v++) drive(v % 2 == 0, v % 2 == 1, 8'(v), 8'(v));
    for (int i = 0; i < 30; i++) drive(1, 1, 8'($urandom), 8'($urandom));
    wait_quiet();
    bp = 0;
    fin = 1;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
